rs_chien_stream: RTL

- Parametrised, handshaked Chien search for the RS decoder. It sits between the Berlekamp-Massey stage and the Forney/correction stage.
- It accepts one error-locator polynomial and evaluates it over every position of a (possibly shortened) codeword, ROOTS_PER_CYCLE positions per clock.
- It returns the error positions packed in ascending order, with a valid mask, a root count and a locator-consistency error flag.
- Compared with the previous generation it adds:
  - shortened-code support;
  - ready/valid back-pressure on both sides;
  - a registered locator copy;
  - the implemented rs_chien_err check.

---
 rtl/rs_chien_stream.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rs_chien_stream.sv
// ---------------------------------------------------------------------------
// gf_pkg / rs_chien_stream
//
// gf_pkg: GF(2^8) arithmetic (primitive polynomial x^8+x^4+x^3+x^2+1).
//
// rs_chien_stream: handshaked Chien search. One error-locator polynomial is
// accepted, evaluated at alpha^-j for every codeword position j in
// 0..N_LEN-1 (ROOTS_PER_CYCLE positions per clock), and the roots are
// returned packed in ascending order together with a mask, a count and a
// locator-consistency flag.
//
// Ports:
//   aclk                  clock
//   areset                synchronous active-high reset
//   error_locator         Lambda coefficients, index k multiplies x^k
//   error_locator_vld     locator valid
//   error_locator_rdy     block idle and able to accept a locator
//   error_positions       packed error positions j, slot 0 = smallest
//   error_positions_mask  bit k set when slot k holds a position
//   error_cnt             number of roots found (saturates at T_LEN)
//   error_positions_vld   result valid, outputs held until accepted
//   error_positions_rdy   downstream accepts result
//   rs_chien_err          locator inconsistent, qualified by _vld
// ---------------------------------------------------------------------------

package gf_pkg;
    localparam int                  SYMB_WIDTH = 8;
    localparam int                  GF_ORDER   = 255;
    localparam logic [SYMB_WIDTH:0] GF_POLY    = 9'h11D;

    function automatic logic [SYMB_WIDTH-1:0] gf_mul_alpha(input logic [SYMB_WIDTH-1:0] a);
        logic [SYMB_WIDTH-1:0] s;
        s = {a[SYMB_WIDTH-2:0], 1'b0};
        if (a[SYMB_WIDTH-1]) begin
            s = s ^ GF_POLY[SYMB_WIDTH-1:0];
        end
        return s;
    endfunction

    function automatic logic [SYMB_WIDTH-1:0] gf_mul(input logic [SYMB_WIDTH-1:0] a,
                                                     input logic [SYMB_WIDTH-1:0] b);
        logic [SYMB_WIDTH-1:0] p;
        logic [SYMB_WIDTH-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = gf_mul_alpha(aa);
        end
        return p;
    endfunction

    // alpha^e for any integer e (negative exponents wrap modulo the field order)
    function automatic logic [SYMB_WIDTH-1:0] gf_alpha_pow(input int e);
        int                    ee;
        logic [SYMB_WIDTH-1:0] p;
        ee = e % GF_ORDER;
        if (ee < 0) begin
            ee = ee + GF_ORDER;
        end
        p = 1;
        for (int i = 0; i < ee; i++) begin
            p = gf_mul_alpha(p);
        end
        return p;
    endfunction
endpackage

// State table
//   state  | meaning
//   IDLE   | ready for a locator; accept registers it and clears the result
//   SEARCH | evaluate ROOTS_PER_CYCLE positions per cycle, collect prior hits
//   FLUSH  | collect the final registered hits, capture locator degree
//   DONE   | result valid and held until downstream handshake
module rs_chien_stream
    import gf_pkg::*;
#(
    parameter int T_LEN           = 8,
    parameter int ROOTS_PER_CYCLE = 16,
    parameter int N_LEN           = 255,
    parameter int CNT_W           = $clog2(T_LEN + 1)
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [T_LEN:0][SYMB_WIDTH-1:0]      error_locator,
    input  logic                                error_locator_vld,
    output logic                                error_locator_rdy,
    output logic [T_LEN-1:0][SYMB_WIDTH-1:0]    error_positions,
    output logic [T_LEN-1:0]                    error_positions_mask,
    output logic [CNT_W-1:0]                    error_cnt,
    output logic                                error_positions_vld,
    input  logic                                error_positions_rdy,
    output logic                                rs_chien_err
);

    localparam int CYCLES = (N_LEN + ROOTS_PER_CYCLE - 1) / ROOTS_PER_CYCLE;
    localparam int C_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int J_W    = $clog2(N_LEN + ROOTS_PER_CYCLE);

    localparam logic [C_W-1:0]   C_LAST  = C_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(T_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_n;

    logic [T_LEN:0][SYMB_WIDTH-1:0]   loc_q;
    logic [SYMB_WIDTH-1:0]            term_q    [T_LEN+1];
    logic [SYMB_WIDTH-1:0]            term_next [T_LEN+1];
    logic [SYMB_WIDTH-1:0]            lane_prod [ROOTS_PER_CYCLE][T_LEN+1];
    logic [SYMB_WIDTH-1:0]            lane_acc;
    logic [C_W-1:0]                   c_q;
    logic [J_W-1:0]                   base;
    logic [ROOTS_PER_CYCLE-1:0]       hit;
    logic [ROOTS_PER_CYCLE-1:0]       hits_q;
    logic [J_W-1:0]                   hits_base_q;
    logic                             hits_vld_q;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0] pos_q;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0] pos_n;
    logic [CNT_W-1:0]                 cnt_q;
    logic [CNT_W-1:0]                 cnt_n;
    logic                             ovf_q;
    logic                             ovf_n;
    logic [CNT_W-1:0]                 deg_q;
    logic [CNT_W-1:0]                 deg_n;

    // term_q[k] holds Lambda_k * alpha^(-k*c*ROOTS_PER_CYCLE); lane l adds the
    // constant twiddle alpha^(-k*l) so that lane l sees position c*RPC + l.
    genvar gk, gl;
    generate
        for (gk = 0; gk <= T_LEN; gk++) begin : g_coef
            localparam logic [SYMB_WIDTH-1:0] STEP = gf_alpha_pow(-(gk * ROOTS_PER_CYCLE));
            assign term_next[gk] = gf_mul(term_q[gk], STEP);
            for (gl = 0; gl < ROOTS_PER_CYCLE; gl++) begin : g_lane
                localparam logic [SYMB_WIDTH-1:0] TWIDDLE = gf_alpha_pow(-(gk * gl));
                assign lane_prod[gl][gk] = gf_mul(term_q[gk], TWIDDLE);
            end
        end
    endgenerate

    always_comb begin
        base     = J_W'(c_q) * J_W'(ROOTS_PER_CYCLE);
        hit      = '0;
        lane_acc = '0;
        for (int l = 0; l < ROOTS_PER_CYCLE; l++) begin
            lane_acc = '0;
            for (int k = 0; k <= T_LEN; k++) begin
                lane_acc = lane_acc ^ lane_prod[l][k];
            end
            // lanes past the end of a shortened/partial final cycle never hit
            hit[l] = (lane_acc == '0) && ((base + J_W'(l)) < J_W'(N_LEN));
        end
    end

    // Pack the previous cycle's hits into the next free slots, lower lane first.
    always_comb begin
        pos_n = pos_q;
        cnt_n = cnt_q;
        ovf_n = ovf_q;
        if (hits_vld_q) begin
            for (int l = 0; l < ROOTS_PER_CYCLE; l++) begin
                if (hits_q[l]) begin
                    if (cnt_n < CNT_MAX) begin
                        for (int s = 0; s < T_LEN; s++) begin
                            if (CNT_W'(s) == cnt_n) begin
                                pos_n[s] = SYMB_WIDTH'(hits_base_q + J_W'(l));
                            end
                        end
                        cnt_n = cnt_n + CNT_W'(1);
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        deg_n = '0;
        for (int k = 0; k <= T_LEN; k++) begin
            if (loc_q[k] != '0) begin
                deg_n = CNT_W'(k);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // FSM: next state
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:   if (error_locator_vld)   state_n = ST_SEARCH;
            ST_SEARCH: if (c_q == C_LAST)       state_n = ST_FLUSH;
            ST_FLUSH:                           state_n = ST_DONE;
            ST_DONE:   if (error_positions_rdy) state_n = ST_IDLE;
            default:                            state_n = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        error_locator_rdy   = (state_q == ST_IDLE);
        error_positions_vld = (state_q == ST_DONE);
        rs_chien_err        = (state_q == ST_DONE) &&
                              ((loc_q[0] == '0) || ovf_q || (cnt_q != deg_q));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            loc_q       <= '0;
            c_q         <= '0;
            hits_q      <= '0;
            hits_base_q <= '0;
            hits_vld_q  <= 1'b0;
            pos_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            deg_q       <= '0;
            for (int k = 0; k <= T_LEN; k++) begin
                term_q[k] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (error_locator_vld) begin
                        loc_q      <= error_locator;
                        c_q        <= '0;
                        hits_vld_q <= 1'b0;
                        pos_q      <= '0;
                        cnt_q      <= '0;
                        ovf_q      <= 1'b0;
                        for (int k = 0; k <= T_LEN; k++) begin
                            term_q[k] <= error_locator[k];
                        end
                    end
                end
                ST_SEARCH: begin
                    c_q         <= c_q + C_W'(1);
                    hits_q      <= hit;
                    hits_base_q <= base;
                    hits_vld_q  <= 1'b1;
                    pos_q       <= pos_n;
                    cnt_q       <= cnt_n;
                    ovf_q       <= ovf_n;
                    for (int k = 0; k <= T_LEN; k++) begin
                        term_q[k] <= term_next[k];
                    end
                end
                ST_FLUSH: begin
                    hits_vld_q <= 1'b0;
                    pos_q      <= pos_n;
                    cnt_q      <= cnt_n;
                    ovf_q      <= ovf_n;
                    deg_q      <= deg_n;
                end
                default: begin
                end
            endcase
        end
    end

    assign error_positions = pos_q;
    assign error_cnt       = cnt_q;

    always_comb begin
        for (int k = 0; k < T_LEN; k++) begin
            error_positions_mask[k] = (CNT_W'(k) < cnt_q);
        end
    end

endmodule
